// File: rtl/mult_pkg.sv
// Shared constants and operation decode for the signed shift-add multiplier datapath.
package mult_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_ADD,
    OP_SUB
  } op_e;

  // Sub takes precedence over Add; neither has any effect unless the multiplier LSB is set.
  function automatic op_e decode_op(input logic add, input logic sub, input logic m);
    op_e op;
    op = OP_NONE;
    if (m && sub) begin
      op = OP_SUB;
    end else if (m && add) begin
      op = OP_ADD;
    end
    return op;
  endfunction

endpackage

// File: rtl/mult_datapath_if.sv
// Strobe/operand bundle between the multiplier control FSM and the datapath.
interface mult_datapath_if #(
  parameter int WIDTH = mult_pkg::DEFAULT_WIDTH
);

  logic             ClearA_LoadB;
  logic             Clr_Ld;
  logic             Shift;
  logic             Add;
  logic             Sub;
  logic [WIDTH-1:0] S;
  logic             M;
  logic             X;
  logic [WIDTH-1:0] Aval;
  logic [WIDTH-1:0] Bval;

  modport master (
    output ClearA_LoadB, Clr_Ld, Shift, Add, Sub, S,
    input  M, X, Aval, Bval
  );

  modport slave (
    input  ClearA_LoadB, Clr_Ld, Shift, Add, Sub, S,
    output M, X, Aval, Bval
  );

endinterface

// File: rtl/adder_9bit.sv
// Ripple-carry add/subtract unit: s = a + b, or a - b when sub is high (two's complement).
module adder_9bit #(
  parameter int W = 9
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] s
);

  logic [W-1:0] b_eff;

  assign b_eff = b ^ {W{sub}};

  // Carry-in of each stage is the majority of the previous stage's inputs; the final carry-out is
  // never formed because the result is modulo 2^W.
  for (genvar gi = 0; gi < W; gi++) begin : g_fa
    logic c_in;
    if (gi == 0) begin : g_first
      assign c_in = sub;
    end else begin : g_chain
      assign c_in = (a[gi-1] & b_eff[gi-1]) |
                    (g_fa[gi-1].c_in & (a[gi-1] ^ b_eff[gi-1]));
    end
    assign s[gi] = a[gi] ^ b_eff[gi] ^ c_in;
  end

endmodule

// File: rtl/mult_datapath.sv
// X/A/B register datapath of the signed shift-add multiplier: single-cycle add-then-shift per step.
module mult_datapath
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic          Clk,
  input  logic          Reset,
  mult_datapath_if.slave bus
);

  localparam int AW = WIDTH + 1;

  logic             x_reg, x_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;

  logic [AW-1:0]    ext_a;
  logic [AW-1:0]    ext_s;
  logic [AW-1:0]    addend;
  logic [AW-1:0]    sum9;
  logic             sub_en;
  logic             load;
  op_e              op;

  // The button load is only honoured while the FSM is idle; the FSM load always wins.
  assign load = bus.Clr_Ld |
                (bus.ClearA_LoadB & ~bus.Shift & ~bus.Add & ~bus.Sub);

  always_comb begin
    op     = decode_op(bus.Add, bus.Sub, b_reg[0]);
    ext_a  = {a_reg[WIDTH-1], a_reg};
    ext_s  = {bus.S[WIDTH-1], bus.S};
    addend = (op == OP_NONE) ? '0 : ext_s;
    sub_en = (op == OP_SUB);
  end

  adder_9bit #(
    .W (AW)
  ) u_adder (
    .a   (ext_a),
    .b   (addend),
    .sub (sub_en),
    .s   (sum9)
  );

  always_comb begin
    x_next = x_reg;
    a_next = a_reg;
    b_next = b_reg;
    if (load) begin
      x_next = 1'b0;
      a_next = '0;
      b_next = bus.S;
    end else if (bus.Shift) begin
      // The 9-bit sum is shifted as a whole, so its sign bit refills both X and A's MSB.
      x_next = sum9[AW-1];
      a_next = sum9[AW-1:1];
      b_next = {sum9[0], b_reg[WIDTH-1:1]};
    end else if (bus.Add || bus.Sub) begin
      x_next = sum9[AW-1];
      a_next = sum9[WIDTH-1:0];
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      x_reg <= 1'b0;
      a_reg <= '0;
      b_reg <= '0;
    end else begin
      x_reg <= x_next;
      a_reg <= a_next;
      b_reg <= b_next;
    end
  end

  assign bus.M    = b_reg[0];
  assign bus.X    = x_reg;
  assign bus.Aval = a_reg;
  assign bus.Bval = b_reg;

endmodule

// File: doc/mult_datapath.md
Name: mult_datapath

Overview:
- Register/arithmetic datapath of the 8-bit signed shift-add multiplier.
- Sits directly downstream of the multiplier control FSM and consumes its Clr_Ld, Shift, Add and Sub strobes.
- Holds the X (sign-extension bit), A (accumulator, upper product byte) and B (multiplier, lower product byte) registers, plus a 9-bit add/subtract unit.
- Returns the current multiplier LSB (M) to the FSM and exposes X, A and B to the display logic.

Parameters:
- WIDTH, 8, operand width; the adder is WIDTH+1 bits and the product is 2*WIDTH bits held in A:B.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high; clears all registers.
- ClearA_LoadB  input  1  direct button request: clear X/A and load B from S. Honoured only when Shift, Add and Sub are all 0.
- Clr_Ld  input  1  FSM strobe: clear X/A and load B from S.
- Shift  input  1  FSM strobe: arithmetic shift right of X:A:B, after the optional add/sub in the same cycle.
- Add  input  1  FSM strobe: A plus S (sign-extended) when M=1.
- Sub  input  1  FSM strobe: A minus S (sign-extended) when M=1.
- S  input  WIDTH  switch operand (multiplicand, also the B load value).
- M  output  1  B[0], combinational from the register.
- X  output  1  sign-extension flip-flop.
- Aval  output  WIDTH  A register.
- Bval  output  WIDTH  B register.

Behaviour:
- Reset (highest priority) forces next state X=0, A=0, B=0, so M=0. Reset asserted mid-multiply aborts the multiply with no residual state.
- Load cycle: Clr_Ld=1, or (ClearA_LoadB=1 with Shift=Add=Sub=0).
  - Next state X=0, A=0, B=S.
  - Load wins over any Shift/Add/Sub asserted in the same cycle.
- Arithmetic term, evaluated combinationally each cycle:
  - ext_A = {X?A[7]:A[7], A} = {A[7], A}; ext_S = {S[7], S}.
  - sum9 = ext_A - ext_S if Sub=1 and M=1.
  - Else sum9 = ext_A + ext_S if Add=1 and M=1.
  - Else sum9 = ext_A.
  - Sub beats Add when both are high. Result is modulo 2^9, with no overflow flag.
- Add/Sub without Shift: X <= sum9[8], A <= sum9[7:0]; B unchanged.
- Shift (with or without Add/Sub): X <= sum9[8], A <= sum9[8:1], B <= {sum9[0], B[7:1]}. This is a single-cycle add-then-shift.
- No strobes active: all registers hold.
- M always reflects the registered B[0]; it is never derived from S or sum9.
- Latency: every strobe takes effect on the first rising edge at which it is sampled high. Outputs are valid the following cycle.
- Protocol expected from the FSM (not enforced):
  - one Clr_Ld;
  - then WIDTH Shift cycles, the first WIDTH-1 with Add and the last with Sub.
  - The result is then in X:A:B, product = {A,B} as a signed 2*WIDTH value, with X = product sign.
- Edge values:
  - S=0x80 with Sub at the final step is correct because of the 9-bit width (see T5).
  - Repeated Shift after completion keeps shifting with X sign-fill; this is not blocked.

Decomposition:
- Package mult_pkg: WIDTH localparam default; op_e enum {OP_NONE, OP_ADD, OP_SUB}, decoded from Add/Sub/M.
- Sub-module adder_9bit (a, b, sub -> s[8:0]):
  - ripple of full adders;
  - b inverted and carry-in=1 when sub=1.
- Register update logic stays in mult_datapath.

Test Plan:
- T1 reset: load B=0x5A, then pulse Reset for 1 cycle -> next cycle X=0, Aval=0x00, Bval=0x00, M=0.
- T2 load/priority: A=0x33, X=1, S=0xC4; Clr_Ld=1 with Shift=1 -> X=0, Aval=0x00, Bval=0xC4, M=0. Then ClearA_LoadB=1 with Shift=1 -> load ignored, shift occurs.
- T3 add/sub without shift:
  - A=0, M=1, S=0x80, Add=1 -> X=1, Aval=0x80.
  - From A=0, M=1, S=0x01, Sub=1 -> X=1, Aval=0xFF.
  - With M=0, Add=1 -> no change.
- T4 plain shift: X=1, A=0x81, B=0x02, Shift=1, M=0 -> X=1, Aval=0xC0, Bval=0x81, M=1.
- T5 full multiplies (Clr_Ld, then 7× Shift+Add, then 1× Shift+Sub):
  - S=0x07, B=0xFD -> Aval=0xFF, Bval=0xEB, X=1 (-21).
  - S=0x7F, B=0x7F -> Aval=0x3F, Bval=0x01, X=0.
  - S=0x80, B=0x80 -> Aval=0x40, Bval=0x00, X=0.
- T6 reset mid-multiply: Reset after the 4th shift of T5 case 1 -> all zero. A fresh Clr_Ld/8-step run then reproduces 0xFF/0xEB.
